// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO slice: default sizing, pointer-width
// helper and the parameter-legality check used at elaboration.
`define FIFO_PARAMS_LEGAL(D, AF, AE) (((D) >= 2) && (((D) & ((D) - 1)) == 0) && ((AF) >= 1) && ((AF) <= (D)) && ((AE) >= 0) && ((AE) <= (D) - 1))

package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int LVL_W     = PTR_W + 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Storage is deliberately left without reset.
module stream_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with registered output stage, occupancy level,
// almost-full/almost-empty flags and synchronous flush.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int ADDR_W = ptr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(AEMPTY_THRESH);

  if (!`FIFO_PARAMS_LEGAL(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
    $error("stream_fifo: DEPTH must be a power of two >= 2 and thresholds in range");
  end

  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_empty;
  logic             load_out;
  logic             take_ram;
  logic             bypass;
  logic             ram_we;

  // The output register always holds the oldest word, so the array is only
  // the overflow behind it; an empty array lets a write go straight to m_data.
  assign s_ready      = (level != FULL_LVL) & ~flush;
  assign wr_acc       = s_valid & s_ready;
  assign rd_acc       = m_valid & m_ready;
  assign ram_empty    = (wr_ptr == rd_ptr);
  assign load_out     = ~m_valid | rd_acc;
  assign take_ram     = ~flush & load_out & ~ram_empty;
  assign bypass       = ~flush & load_out & ram_empty & wr_acc;
  assign ram_we       = wr_acc & ~bypass;
  assign almost_full  = (level >= AFULL_LVL);
  assign almost_empty = (level <= AEMPTY_LVL);

  stream_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else if (flush) begin
      level   <= '0;
      m_valid <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (wr_acc && !rd_acc) begin
        level <= level + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        level <= level - 1'b1;
      end
      if (ram_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (take_ram) begin
        rd_ptr <= rd_ptr + 1'b1;
        m_data <= ram_rdata;
      end else if (bypass) begin
        m_data <= s_data;
      end
      if (load_out) begin
        m_valid <= take_ram | bypass;
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: stimulus pushes expected words, a monitor
// pops them whenever the output handshake completes.
module tb_stream_fifo;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             flush   = 1'b0;
  logic [WIDTH-1:0] s_data  = '0;
  logic             s_valid = 1'b0;
  logic             m_ready = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             almost_empty;

  int               vec_cnt     = 0;
  int               miss_cnt    = 0;
  int               model_level = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  stream_fifo #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; the model count decides what the DUT must show.
  task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] sd, input logic mr, input logic fl);
    logic exp_ready;
    logic wr;
    logic rd;
    s_valid = sv;
    s_data  = sd;
    flush   = fl;
    m_ready = ~mr;
    #1;
    exp_ready = (model_level != DEPTH) && !fl;
    checkOutput("s_ready_opposite_m_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    m_ready = mr;
    #1;
    checkOutput("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    checkOutput("level", 32'(level), 32'(model_level));
    checkOutput("m_valid", {31'd0, m_valid}, {31'd0, model_level != 0});
    checkOutput("almost_full", {31'd0, almost_full}, {31'd0, model_level >= AF});
    checkOutput("almost_empty", {31'd0, almost_empty}, {31'd0, model_level <= AE});
    wr = sv & exp_ready;
    rd = (model_level != 0) & mr & ~fl;
    if (wr) exp_q.push_back(sd);
    if (fl) model_level = 0;
    else if (wr && !rd) model_level++;
    else if (rd && !wr) model_level--;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss_cnt++;
        $display("[TB] FAIL m_data_unexpected: got 0x%0h, expected no word at %0t", m_data, $time);
      end else begin
        checkOutput("m_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int pw;
    int pr;
    #2;
    checkOutput("reset_level", 32'(level), 0);
    checkOutput("reset_m_valid", {31'd0, m_valid}, 0);
    checkOutput("reset_m_data", 32'(m_data), 0);
    checkOutput("reset_s_ready", {31'd0, s_ready}, 1);
    checkOutput("reset_almost_full", {31'd0, almost_full}, 0);
    checkOutput("reset_almost_empty", {31'd0, almost_empty}, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill to full with m_ready low");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
      if (i == 0) checkOutput("first_word_latency", 32'(m_data), 32'h11);
    end

    $display("[TB] drain full FIFO");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] streaming write+read");
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] flush at level 5");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("flush_m_data_hold", 32'(m_data), 32'h40);
    checkOutput("flush_m_valid", {31'd0, m_valid}, 0);
    checkOutput("flush_level", 32'(level), 0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      pw = (i % 2000 < 1000) ? 70 : 35;
      pr = (i % 2000 < 1000) ? 35 : 70;
      applyStimulus(($urandom_range(0, 99) < pw), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < pr), 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] asynchronous reset mid-burst");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_level", 32'(level), 0);
    checkOutput("async_reset_m_valid", {31'd0, m_valid}, 0);
    checkOutput("async_reset_m_data", 32'(m_data), 0);
    checkOutput("async_reset_s_ready", {31'd0, s_ready}, 1);
    checkOutput("async_reset_almost_full", {31'd0, almost_full}, 0);
    checkOutput("async_reset_almost_empty", {31'd0, almost_empty}, 1);
    exp_q.delete();
    model_level = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("post_reset_m_valid", {31'd0, m_valid}, 1);
    checkOutput("post_reset_m_data", 32'(m_data), 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("final_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
